// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if : hazard-unit pipeline signals (ID/EX fields, stall/flush controls)
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_is_mul;
  logic        branch_taken;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_en;
  logic        id_ex_bubble;
  logic        mul_start;
  logic        busy;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, ex_memread, ex_rt, ex_is_mul, branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, mul_start, busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_memread, ex_rt, ex_is_mul, branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, mul_start, busy, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : load-use / multi-cycle multiply / branch-flush hazard control
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] C_WAIT_INIT = 4'(MUL_LAT - 2);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_stall_cnt;

  logic w_load_use;
  logic w_mul_go;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_if_id_flush;
  logic w_id_ex_en;
  logic w_id_ex_bubble;
  logic w_mul_start;

  // Register 0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign w_load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
  assign w_mul_go   = (r_state == ST_RUN) && !bus.branch_taken && bus.ex_is_mul;

  always_comb begin
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_en     = 1'b1;
    w_id_ex_bubble = 1'b0;
    w_mul_start    = 1'b0;
    if (!rst_n) begin
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
    end else if (r_state == ST_MUL_WAIT) begin
      if (r_cnt != 4'd0) begin
        w_pc_en    = 1'b0;
        w_if_id_en = 1'b0;
        w_id_ex_en = 1'b0;
      end
    end else if (bus.branch_taken) begin
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
    end else if (bus.ex_is_mul) begin
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_mul_start = 1'b1;
    end else if (w_load_use) begin
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (!w_pc_en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      case (r_state)
        ST_RUN: begin
          if (w_mul_go) begin
            r_state <= ST_MUL_WAIT;
            r_cnt   <= C_WAIT_INIT;
          end
        end
        ST_MUL_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_en     = w_id_ex_en;
  assign bus.id_ex_bubble = w_id_ex_bubble;
  assign bus.mul_start    = w_mul_start;
  assign bus.busy         = (r_state == ST_MUL_WAIT);
  assign bus.stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire
